// File: rtl/fft_frame_sched.sv
// Double-buffered 16-sample frame scheduler: fills ping-pong banks from the FIR, launches the
// FFT engine, captures bins and streams them out. Optional peak tracker: FFT_FRAME_SCHED_PEAK_EN.
module fft_frame_sched #(
    parameter int DW = 16,
    parameter int RW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fir_valid,
    input  logic signed [DW-1:0] fir_d,
    output logic                 fft_start,
    output logic [16*DW-1:0]     fft_x,
    input  logic                 fft_done,
    input  logic [16*RW-1:0]     fft_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_bin,
    output logic [RW-1:0]        out_data,
    output logic                 out_last,
    output logic                 ovf,
    output logic                 peak_valid,
    output logic [3:0]           peak_bin
);

    // state | meaning
    // IDLE  | waiting for the read bank to fill
    // START | one-cycle launch pulse to the engine
    // WAIT  | engine busy, bank held for fft_x
    // DRAIN | streaming captured bins out
    typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   bank_q [2][16];
    logic [RW-1:0]   res_q  [16];
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [3:0]      wr_idx_q, wr_idx_d;
    logic [3:0]      k_q, k_d;
    logic            ovf_q, ovf_d;
    logic            wr_en, cap_en, hs;

    assign hs = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        k_d       = k_q;
        ovf_d     = ovf_q;
        wr_en     = 1'b0;
        cap_en    = 1'b0;

        if (fir_valid) begin
            if (full_q[wr_bank_q]) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wr_idx_q == 4'd15) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_idx_d          = 4'd0;
                end else begin
                    wr_idx_d = wr_idx_q + 4'd1;
                end
            end
        end

        case (state_q)
            IDLE:  if (full_q[rd_bank_q]) state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (fft_done) begin
                    // Release targets the read bank; a same-cycle fill can only hit the other bank.
                    cap_en            = 1'b1;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    k_d               = 4'd0;
                    state_d           = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (k_q == 4'd15) begin
                        k_d     = 4'd0;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= 4'd0;
            k_q       <= 4'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            k_q       <= k_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 16; i++)
                    bank_q[b][i] <= '0;
            for (int i = 0; i < 16; i++)
                res_q[i] <= '0;
        end else begin
            if (wr_en)
                bank_q[wr_bank_q][wr_idx_q] <= fir_d;
            if (cap_en)
                for (int i = 0; i < 16; i++)
                    res_q[i] <= fft_res[i*RW +: RW];
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_fft_x
        assign fft_x[g*DW +: DW] = bank_q[rd_bank_q][g];
    end

    assign fft_start = (state_q == START);
    assign out_valid = (state_q == DRAIN);
    assign out_bin   = out_valid ? k_q : 4'd0;
    assign out_data  = out_valid ? res_q[k_q] : '0;
    assign out_last  = out_valid && (k_q == 4'd15);
    assign ovf       = ovf_q;

`ifdef FFT_FRAME_SCHED_PEAK_EN
    logic [15:0] re, im, abs_re, abs_im;
    logic [16:0] mag, best_mag_q;
    logic [3:0]  best_bin_q, peak_bin_q;
    logic        peak_valid_q, take;

    assign re     = res_q[k_q][RW-1 -: 16];
    assign im     = res_q[k_q][15:0];
    assign abs_re = re[15] ? (~re + 16'd1) : re;
    assign abs_im = im[15] ? (~im + 16'd1) : im;
    assign mag    = {1'b0, abs_re} + {1'b0, abs_im};
    // Strict compare keeps the lowest index on ties; bin 0 always seeds the search.
    assign take   = (k_q == 4'd0) || (mag > best_mag_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_mag_q   <= '0;
            best_bin_q   <= 4'd0;
            peak_bin_q   <= 4'd0;
            peak_valid_q <= 1'b0;
        end else begin
            peak_valid_q <= hs && (k_q == 4'd15);
            if (hs && take) begin
                best_mag_q <= mag;
                best_bin_q <= k_q;
            end
            if (hs && (k_q == 4'd15))
                peak_bin_q <= take ? k_q : best_bin_q;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_bin   = peak_bin_q;
`else
    assign peak_valid = 1'b0;
    assign peak_bin   = 4'd0;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: behavioural FFT engine, bin scoreboard, stall and peak monitors.
module tb_fft_frame_sched;

    localparam int DW = 16;
    localparam int RW = 32;

    logic                 clk, rst, fir_valid, fft_start, fft_done, out_valid, out_ready;
    logic signed [DW-1:0] fir_d;
    logic [16*DW-1:0]     fft_x;
    logic [16*RW-1:0]     fft_res;
    logic [3:0]           out_bin, peak_bin;
    logic [RW-1:0]        out_data;
    logic                 out_last, ovf, peak_valid;

    fft_frame_sched #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .fft_start(fft_start), .fft_x(fft_x), .fft_done(fft_done), .fft_res(fft_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_data(out_data), .out_last(out_last), .ovf(ovf),
        .peak_valid(peak_valid), .peak_bin(peak_bin)
    );

    typedef struct {
        logic [3:0]    bin;
        logic [RW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0, failures = 0;
    int            done_delay = 1, start_cnt = 0, peak_cnt = 0, rcnt = 0;
    bit            ready_mode = 0, peak_mode = 0;
    logic          eng_done = 0, man_done = 0;
    logic [3:0]    peak_seen = 0;

    assign fft_done = eng_done | man_done;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [RW-1:0] eng_bin(input int j, input logic [15:0] s, input bit pk);
        if (pk) begin
            if (j == 5) return {16'h0100, 16'hFF00};
            if (j == 9) return {16'hFF00, 16'h0100};
            return '0;
        end
        return {s, 16'(j)};
    endfunction

    // Engine model: answers each launch after done_delay cycles.
    initial begin
        fft_res = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && fft_start === 1'b1) begin
                start_cnt++;
                for (int j = 0; j < 16; j++)
                    fft_res[j*RW +: RW] = eng_bin(j, fft_x[j*DW +: DW], peak_mode);
                repeat (done_delay) @(negedge clk);
                eng_done = 1;
                @(negedge clk);
                eng_done = 0;
            end
        end
    end

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                out_ready = (rcnt % 3 == 0);
                rcnt++;
            end else begin
                out_ready = 1;
            end
        end
    end

    // Output monitor: scoreboard pop on handshake, hold check while stalled.
    bit            stall = 0;
    logic [3:0]    h_bin;
    logic [RW-1:0] h_data;
    logic          h_last;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            stall = 0;
        end else begin
            if (stall && out_valid) begin
                chk("hold_bin", out_bin, h_bin);
                chk("hold_data", out_data, h_data);
                chk("hold_last", out_last, h_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_bin", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_bin", out_bin, e.bin);
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                end
            end
            stall  = out_valid && !out_ready;
            h_bin  = out_bin;
            h_data = out_data;
            h_last = out_last;
        end
        if (peak_valid === 1'b1) begin
            peak_cnt++;
            peak_seen = peak_bin;
        end
    end

    task automatic push_frame(input int base);
        for (int j = 0; j < 16; j++) begin
            exp_t e;
            e.bin  = 4'(j);
            e.data = eng_bin(j, 16'(base + j), peak_mode);
            e.last = (j == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fir_valid = 1;
            fir_d     = 16'(base + i);
            @(negedge clk);
        end
        fir_valid = 0;
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 0; fir_valid = 0; fir_d = 0;
        #1;
        chk("rst_fft_start", fft_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bin", out_bin, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_bin", peak_bin, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);

        // Stray done while idle is ignored
        man_done = 1;
        @(negedge clk);
        man_done = 0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_done_valid", out_valid, 0);
            chk("idle_done_start", fft_start, 0);
        end

        // Basic frame 1..16 with launch latency
        push_frame(1);
        send(1, 16);
        chk("lat_start_early", fft_start, 0);
        @(negedge clk);
        chk("lat_start", fft_start, 1);
        chk("fft_x_slot0", fft_x[0 +: DW], 16'd1);
        chk("fft_x_slot15", fft_x[15*DW +: DW], 16'd16);
        @(negedge clk);
        chk("start_one_cycle", fft_start, 0);
        wait_empty("drain_basic", 100);
        chk("start_cnt_basic", start_cnt, 1);
        chk("ovf_basic", ovf, 0);

        // Backpressure 1,0,0 pattern
        ready_mode = 1;
        push_frame(100);
        send(100, 16);
        wait_empty("drain_stall", 200);
        ready_mode = 0;
        chk("start_cnt_stall", start_cnt, 2);

        // Overflow: third frame dropped while engine is slow
        done_delay = 40;
        push_frame(200);
        push_frame(216);
        send(200, 48);
        chk("ovf_set", ovf, 1);
        wait_empty("drain_ovf", 400);
        done_delay = 1;
        repeat (20) @(negedge clk);
        chk("start_cnt_ovf", start_cnt, 4);
        chk("no_extra_out", out_valid, 0);

        // Reset mid-drain at bin 7
        push_frame(300);
        send(300, 16);
        n = 0;
        while (!(out_valid === 1'b1 && out_bin == 4'd7) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bin7", n < 100, 1);
        #1 rst = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_bin", out_bin, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_start", fft_start, 0);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        n = start_cnt;
        push_frame(400);
        send(400, 16);
        @(negedge clk);
        chk("fresh_slot0", fft_x[0 +: DW], 16'd400);
        chk("fresh_slot15", fft_x[15*DW +: DW], 16'd415);
        wait_empty("drain_fresh", 100);
        chk("fresh_one_start", start_cnt, n + 1);

        // Peak frame: bins 5 and 9 tie, lowest index wins
        peak_mode = 1;
        peak_cnt  = 0;
        push_frame(500);
        send(500, 16);
        wait_empty("drain_peak", 100);
`ifdef FFT_FRAME_SCHED_PEAK_EN
        chk("peak_pulses", peak_cnt, 1);
        chk("peak_bin", peak_seen, 5);
`else
        chk("peak_pulses", peak_cnt, 0);
        chk("peak_bin_tied", peak_bin, 0);
`endif
        chk("final_idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
